calc_param_obf: RTL and testbench
=================================

CALC_PARAM_OBF -- requirements
Module: calc_param_obf

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits, legal range 8..64.
REQ-002 Parameter MUL_LAT, default 2, multiply latency in cycles, legal range 1..8.
REQ-003 Parameter THRESH, WIDTH bits, default 32'hAA55_FEDD, signed compare threshold for op 3.
REQ-004 Parameter KEY_W, default 128, locking key width, legal range WIDTH+1..256.
REQ-005 Parameter KEY_VAL, KEY_W bits, default all-ones, the unlocking key.
REQ-006 ap_clk  in  1  single clock, all state on rising edge.
REQ-007 ap_rst_n  in  1  asynchronous active-low reset.
REQ-008 ap_start  in  1  request; operands and op are sampled when ap_start=1 in S_IDLE.
REQ-009 ap_continue  in  1  consumer acknowledge of ap_done.
REQ-010 op  in  2  operation: 0 add, 1 multiply, 2 subtract (a-b), 3 select.
REQ-011 a, b  in  WIDTH each  signed operands.
REQ-012 locking_key  in  KEY_W  obfuscation key.
REQ-013 ap_done, ap_idle, ap_ready  out  1 each  control handshake.
REQ-014 ap_return  out  WIDTH  registered result.

Function
REQ-015 FSM states: S_IDLE, S_CALC, S_DONE, one-hot encoded.
REQ-016 S_IDLE: ap_idle=1; on ap_start=1, latch a, b, op into input registers, ap_ready=1 for that cycle, go to S_CALC.
REQ-017 S_CALC: cycle counter loads 0 on entry; ops 0/2 leave after 1 cycle; ops 1/3 leave after MUL_LAT cycles.
REQ-018 On leaving S_CALC, ap_return is loaded with the obfuscated result, then the FSM enters S_DONE.
REQ-019 S_DONE: ap_done=1 and ap_return is held stable; ap_continue=1 returns to S_IDLE on the next edge.
REQ-020 ap_continue=1 outside S_DONE has no effect.
REQ-021 ap_start=1 outside S_IDLE is ignored, and the latched operands are not disturbed.
REQ-022 Op 0/1/2 results are the two's-complement low WIDTH bits of a+b, a*b and a-b; overflow wraps silently.
REQ-023 Op 3: s=a+b (wrapped); result is a*b (low WIDTH bits) if signed s > THRESH, else s.
REQ-024 The mask m is locking_key[WIDTH-1:0] XOR KEY_VAL[WIDTH-1:0].
REQ-025 ap_return = result XOR m.
REQ-026 If locking_key[KEY_W-1:WIDTH] differs from the same bits of KEY_VAL, the op 3 comparison polarity is inverted (s <= THRESH selects the product).
REQ-027 The key is sampled combinationally during S_CALC only; a key change in S_DONE does not alter the held ap_return.
REQ-028 Handshake outputs are independent of the key.
REQ-029 When locking_key equals KEY_VAL, function equals the unobfuscated spec exactly.
REQ-030 Back-to-back: ap_start held high gives a new acceptance on the cycle after S_DONE exits.
REQ-031 Throughput: one operation per 3 cycles (add) or MUL_LAT+2 cycles (mul/select), plus the wait for ap_continue.

Reset
REQ-032 While ap_rst_n=0: FSM in S_IDLE; ap_return, input registers and counter at 0; ap_idle=1; ap_done=0; ap_ready=0.
REQ-033 Reset asserted in S_CALC or S_DONE aborts the operation with no ap_done pulse.
REQ-034 After ap_rst_n deasserts, the first accepted ap_start is honoured on the first rising edge.

Verification
REQ-035 Correct key, WIDTH=32, op=0, a=5, b=7, ap_continue=1 -> ap_ready at cycle 0, ap_done at cycle 2, ap_return=12.
REQ-036 Correct key, op=1, a=-3, b=4, MUL_LAT=2 -> ap_return=32'hFFFF_FFF4 after 2 cycles in S_CALC.
REQ-037 Correct key, op=3, a=b=32'h4000_0000 (s wraps to 32'h8000_0000, negative, not > THRESH) -> ap_return=32'h8000_0000; then a=b=1 (s=2 > THRESH) -> ap_return=1.
REQ-038 locking_key low bits flipped at bit 0 only, op=0, a=1, b=1 -> ap_return=3; upper key bits wrong on the REQ-037 cases -> the selected results swap.
REQ-039 ap_continue held 0 for 10 cycles in S_DONE -> ap_done stays 1 and ap_return is constant; ap_start pulses are ignored; ap_continue=1 -> ap_idle=1 on the next cycle.
REQ-040 ap_rst_n pulsed low mid-S_CALC -> all outputs at their reset values asynchronously; no ap_done; the next op completes normally.

Source files
------------

// File: rtl/calc_param_obf.sv
// calc_param_obf: key-locked add/multiply/subtract/select unit with ap_ctrl_hs style handshake
module calc_param_obf #(
    parameter int               WIDTH   = 32,
    parameter int               MUL_LAT = 2,
    parameter logic [WIDTH-1:0] THRESH  = WIDTH'(32'hAA55_FEDD),
    parameter int               KEY_W   = 128,
    parameter logic [KEY_W-1:0] KEY_VAL = '1
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    input  logic             ap_continue,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [KEY_W-1:0] locking_key,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    output logic [WIDTH-1:0] ap_return
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_CALC = 3'b010,
        S_DONE = 3'b100
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_ret;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_mask;
    logic             w_key_ok;
    logic             w_sel;
    logic             w_last;

    assign w_sum    = r_a + r_b;
    assign w_diff   = r_a - r_b;
    assign w_prod   = r_a * r_b;
    assign w_mask   = locking_key[WIDTH-1:0] ^ KEY_VAL[WIDTH-1:0];
    assign w_key_ok = locking_key[KEY_W-1:WIDTH] == KEY_VAL[KEY_W-1:WIDTH];
    // A wrong upper key silently flips the select polarity
    assign w_sel    = ($signed(w_sum) > $signed(THRESH)) ^ ~w_key_ok;
    assign w_res    = (r_op == 2'd0) ? w_sum :
                      (r_op == 2'd1) ? w_prod :
                      (r_op == 2'd2) ? w_diff :
                      (w_sel ? w_prod : w_sum);
    // Add/subtract (op bit 0 clear) finish in one cycle, multiply/select take MUL_LAT
    assign w_last   = ~r_op[0] | (r_cnt == 4'(MUL_LAT - 1));
    assign ap_return = r_ret;

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state and handshake outputs, independent of the key
    always_comb begin
        w_next   = r_state;
        ap_idle  = 1'b0;
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                ap_idle  = 1'b1;
                ap_ready = ap_start;
                w_next   = ap_start ? S_CALC : S_IDLE;
            end
            S_CALC: w_next = w_last ? S_DONE : S_CALC;
            S_DONE: begin
                ap_done = 1'b1;
                w_next  = ap_continue ? S_IDLE : S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, latency counter and masked result register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_cnt <= '0;
            r_ret <= '0;
        end else begin
            if (r_state == S_IDLE && ap_start) begin
                r_a   <= a;
                r_b   <= b;
                r_op  <= op;
                r_cnt <= '0;
            end
            if (r_state == S_CALC) begin
                r_cnt <= r_cnt + 4'd1;
                if (w_last)
                    r_ret <= w_res ^ w_mask;
            end
        end
    end

endmodule

// File: tb/tb_calc_param_obf.sv
// tb_calc_param_obf: directed checks of calc_param_obf arithmetic, key locking and handshake
module tb_calc_param_obf;

    logic         ap_clk = 1'b0;
    logic         ap_rst_n;
    logic         ap_start;
    logic         ap_continue;
    logic [1:0]   op;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [127:0] locking_key;
    logic         ap_done;
    logic         ap_idle;
    logic         ap_ready;
    logic [31:0]  ap_return;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] r;

    calc_param_obf dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .ap_start(ap_start),
        .ap_continue(ap_continue),
        .op(op),
        .a(a),
        .b(b),
        .locking_key(locking_key),
        .ap_done(ap_done),
        .ap_idle(ap_idle),
        .ap_ready(ap_ready),
        .ap_return(ap_return)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation from S_IDLE and wait (bounded) for ap_done
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int calc_cycles, input logic cont, output logic [31:0] res);
        int n;
        @(negedge ap_clk);
        op = o; a = x; b = y; ap_start = 1'b1; ap_continue = cont;
        #1 chk("ready", 32'(ap_ready), 32'd1);
        @(negedge ap_clk);
        ap_start = 1'b0;
        n = 0;
        while (!ap_done && n < 20) begin
            @(negedge ap_clk);
            n++;
        end
        chk("calc_cycles", 32'(n), 32'(calc_cycles));
        res = ap_return;
    endtask

    initial begin
        ap_rst_n = 1'b0; ap_start = 1'b0; ap_continue = 1'b0;
        op = '0; a = '0; b = '0; locking_key = '1;
        #12;
        chk("rst_idle",  32'(ap_idle),  32'd1);
        chk("rst_done",  32'(ap_done),  32'd0);
        chk("rst_ready", 32'(ap_ready), 32'd0);
        chk("rst_ret",   ap_return,     32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        do_op(2'd0, 32'd5, 32'd7, 1, 1'b1, r);
        chk("add_5_7", r, 32'd12);
        @(negedge ap_clk);
        chk("idle_after_add", 32'(ap_idle), 32'd1);
        do_op(2'd1, 32'hFFFF_FFFD, 32'd4, 2, 1'b1, r);
        chk("mul_m3_4", r, 32'hFFFF_FFF4);
        do_op(2'd2, 32'd3, 32'd10, 1, 1'b1, r);
        chk("sub_3_10", r, 32'hFFFF_FFF9);
        do_op(2'd2, 32'h8000_0000, 32'd1, 1, 1'b1, r);
        chk("sub_wrap", r, 32'h7FFF_FFFF);
        do_op(2'd0, 32'hFFFF_FFFF, 32'd2, 1, 1'b1, r);
        chk("add_wrap", r, 32'd1);
        do_op(2'd1, 32'h0001_0000, 32'h0001_0003, 2, 1'b1, r);
        chk("mul_wrap", r, 32'h0003_0000);
        do_op(2'd3, 32'h4000_0000, 32'h4000_0000, 2, 1'b1, r);
        chk("sel_sum", r, 32'h8000_0000);
        do_op(2'd3, 32'd1, 32'd1, 2, 1'b1, r);
        chk("sel_prod", r, 32'd1);
        do_op(2'd3, 32'd3, 32'd5, 2, 1'b1, r);
        chk("sel_prod_15", r, 32'd15);

        locking_key = '1; locking_key[0] = 1'b0;
        do_op(2'd0, 32'd1, 32'd1, 1, 1'b1, r);
        chk("badlow_add", r, 32'd3);
        locking_key = '1; locking_key[127] = 1'b0;
        do_op(2'd3, 32'h4000_0000, 32'h4000_0000, 2, 1'b1, r);
        chk("badhigh_sel_a", r, 32'd0);
        do_op(2'd3, 32'd1, 32'd1, 2, 1'b1, r);
        chk("badhigh_sel_b", r, 32'd2);
        do_op(2'd0, 32'd20, 32'd22, 1, 1'b1, r);
        chk("badhigh_add", r, 32'd42);

        locking_key = '1;
        do_op(2'd0, 32'd9, 32'd6, 1, 1'b0, r);
        chk("hold_first", r, 32'd15);
        for (int i = 0; i < 10; i++) begin
            ap_start = 1'b1;
            a = $urandom;
            locking_key[7:0] = 8'(i + 1);
            @(negedge ap_clk);
            chk("hold_done", 32'(ap_done), 32'd1);
            chk("hold_ret", ap_return, 32'd15);
        end
        ap_start = 1'b0; locking_key = '1; ap_continue = 1'b1;
        @(negedge ap_clk);
        chk("cont_idle", 32'(ap_idle), 32'd1);
        chk("cont_done", 32'(ap_done), 32'd0);

        op = 2'd1; a = 32'd3; b = 32'd5; ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        chk("calc_not_idle", 32'(ap_idle), 32'd0);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("arst_idle", 32'(ap_idle), 32'd1);
        chk("arst_done", 32'(ap_done), 32'd0);
        chk("arst_ret",  ap_return,    32'd0);
        @(negedge ap_clk);
        chk("arst_hold_done", 32'(ap_done), 32'd0);
        ap_rst_n = 1'b1;
        do_op(2'd1, 32'd6, 32'd7, 2, 1'b1, r);
        chk("post_rst_mul", r, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
